dff_en_led_bank: RTL



---
 rtl/dff_en_led_bank_pkg.sv | 20 ++
 rtl/dff_en_led_bank_if.sv | 26 ++
 rtl/dff_en_led_bank_led_stretch.sv | 43 ++++
 rtl/dff_en_led_bank.sv | 66 ++++++
 4 files changed

// File: rtl/dff_en_led_bank_pkg.sv
// Shared types and constants for the LED register bank: operating modes,
// LED drive selection and the stretch counter sizing helper.
package dff_en_led_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_LOAD   = 2'b01,
      MODE_SHIFT  = 2'b10,
      MODE_ROTATE = 2'b11
   } mode_e;

   localparam int LED_MIRROR   = 0;
   localparam int LED_ACTIVITY = 1;

   // Counter must hold the value STRETCH itself, hence the +1.
   function automatic int cnt_width(input int stretch);
      return $clog2(stretch + 1);
   endfunction

endpackage

// File: rtl/dff_en_led_bank_if.sv
// Command and status bundle of the LED register bank. The bank is the slave;
// whatever issues mode/data commands and watches the outputs is the master.
interface dff_en_led_bank_if
   import dff_en_led_pkg::*;
#(
   parameter int WIDTH = 8
);
   mode_e              mode_i;
   logic [WIDTH-1:0]   en_i;
   logic [WIDTH-1:0]   d_i;
   logic               ser_i;
   logic [WIDTH-1:0]   q_o;
   logic               ser_o;
   logic [WIDTH-1:0]   led_o;
   logic               changed_o;

   modport master (
      output mode_i, en_i, d_i, ser_i,
      input  q_o, ser_o, led_o, changed_o
   );

   modport slave (
      input  mode_i, en_i, d_i, ser_i,
      output q_o, ser_o, led_o, changed_o
   );
endinterface

// File: rtl/dff_en_led_bank_led_stretch.sv
// One activity-stretch down-counter: a trigger reloads STRETCH, the counter
// then runs down to zero. The LED output is a flop, so it cannot glitch.
module led_stretch
   import dff_en_led_pkg::*;
#(
   parameter int STRETCH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic trig_i,
   output logic led_o
);

   localparam int            CW       = cnt_width(STRETCH);
   localparam logic [CW-1:0] LOAD_VAL = CW'(STRETCH);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          led_r;

   always_comb begin
      cnt_next = cnt;
      if (trig_i) begin
         cnt_next = LOAD_VAL;
      end else if (cnt != '0) begin
         cnt_next = cnt - 1'b1;
      end
   end

   // led_r tracks cnt != 0 by decoding the value being loaded into cnt.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt   <= '0;
         led_r <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         led_r <= (cnt_next != '0);
      end
   end

   assign led_o = led_r;

endmodule

// File: rtl/dff_en_led_bank.sv
// WIDTH-bit hold/load/shift/rotate register with per-bit LED drive that either
// mirrors the stored bit or shows a stretched activity pulse.
module dff_en_led_bank
   import dff_en_led_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               LED_MODE  = LED_MIRROR,
   parameter int               STRETCH   = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   dff_en_led_bank_if.slave bus
);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] diff;
   logic             changed_r;

   always_comb begin
      q_next = q;
      case (bus.mode_i)
         MODE_HOLD:   q_next = q;
         MODE_LOAD:   q_next = (bus.en_i & bus.d_i) | (~bus.en_i & q);
         MODE_SHIFT:  q_next = {q[WIDTH-2:0], bus.ser_i};
         MODE_ROTATE: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         default:     q_next = q;
      endcase
   end

   assign diff = q_next ^ q;

   // Reset edges never count as a change, whatever q did.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q         <= RESET_VAL;
         changed_r <= 1'b0;
      end else begin
         q         <= q_next;
         changed_r <= |diff;
      end
   end

   assign bus.q_o       = q;
   assign bus.ser_o     = q[WIDTH-1];
   assign bus.changed_o = changed_r;

   if (LED_MODE == LED_ACTIVITY) begin : g_activity
      logic [WIDTH-1:0] led_act;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         led_stretch #(
            .STRETCH (STRETCH)
         ) u_led_stretch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .trig_i (diff[i]),
            .led_o  (led_act[i])
         );
      end
      assign bus.led_o = led_act;
   end else begin : g_mirror
      assign bus.led_o = q;
   end

endmodule
